dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Responder end of the core's data-memory port: accepts dmem_addr/rmask/wmask/wdata requests from the memory stage.
// - Returns dmem_rdata and a one-cycle dmem_resp pulse after a programmable wait.
// - Backed by a byte-writable word array; serves as the data memory for the pipeline (sim and FPGA top).
// - The core holds its request stable (freeze_stall) until dmem_resp; this block honours that contract.
// PARAMETERS
// - LATENCY     2   number of WAIT cycles between accept and response; legal range >=1 (elaboration $error if 0)
// - DEPTH_LOG2  12  log2 of array depth in 32-bit words
// PORTS
// - clk         in   1   single clock, rising edge
// - rst         in   1   synchronous, active-high reset
// - dmem_addr   in   32  word-aligned address; bits [1:0] ignored; index = addr[DEPTH_LOG2+1:2]; upper bits ignored
// - dmem_rmask  in   4   byte read enables; nonzero = read request
// - dmem_wmask  in   4   byte write enables; nonzero = write request
// - dmem_wdata  in   32  write data, already lane-aligned by the core
// - dmem_rdata  out  32  full read word (core extracts lanes); valid only while dmem_resp=1
// - dmem_resp   out  1   one-cycle completion pulse
// - dmem_busy   out  1   high in WAIT and RESP states
// - dmem_err    out  1   pulses with dmem_resp when the request had both rmask and wmask nonzero
// BEHAVIOUR
// - Reset values: dmem_rdata=0, dmem_resp=0, dmem_err=0, dmem_busy=0, state=IDLE, cnt=0.
// - Reset leaves array contents untouched.
// - Request present = (|dmem_rmask) | (|dmem_wmask).
// - FSM states: IDLE, WAIT, RESP.
// - IDLE: if request present at the edge:
//   - capture addr index, rmask, wmask, wdata;
//   - cnt<=LATENCY-1; ->WAIT.
//   - Otherwise stay in IDLE.
// - WAIT, cnt!=0: cnt<=cnt-1.
//   - Input changes during WAIT are ignored; only the captured copy is used.
// - WAIT, cnt==0 at the edge:
//   - if captured wmask!=0: array[idx] byte lanes with wmask bit set <= wdata lanes; dmem_rdata<=0;
//   - else: dmem_rdata<=array[idx] (full word, regardless of rmask pattern);
//   - dmem_resp<=1; dmem_err<=(rmask!=0 && wmask!=0); ->RESP.
// - RESP (exactly one cycle): dmem_resp=1; next edge: dmem_resp<=0, dmem_err<=0, ->IDLE.
//   - Inputs in this cycle still show the completed request and are NOT sampled.
// - dmem_rdata holds its last value after resp falls.
// - Timing: request first seen in IDLE in cycle T -> dmem_resp high in cycle T+LATENCY+1.
//   - Back-to-back requests: next accept at T+LATENCY+2 at the earliest.
// - Conflict (rmask and wmask both nonzero): treated as a write, rdata=0, dmem_err=1 with resp.
// - Write commit happens only at the WAIT->RESP edge.
//   - Reset in IDLE/WAIT discards the pending request with no array update and no resp.
//   - Reset in RESP forces resp low next cycle.
// - Read of a word written by the immediately previous request returns the new data (commit precedes next accept).
// STRUCTURE
// - rv32i_types gains:
//   - typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_resp_state_t;
//   - typedef struct packed {idx, rmask, wmask, wdata} dmem_req_t.
// - Sub-module dmem_byte_ram: sync write with 4-bit byte enables, registered read.
//   - Ports: clk, we, be, idx, wdata, rdata; no reset; parameter DEPTH_LOG2.
// - Top: FSM, cnt register of width $clog2(LATENCY+1), request capture register.
// TESTING
// - Reset, then idle with masks=0 for 10 cycles -> resp, busy, err stay 0; rdata=0.
// - LATENCY=2: sw 0xDEADBEEF @0x100 (wmask=F) at cycle T -> resp only in cycle T+3; then lw @0x100 -> rdata=0xDEADBEEF.
// - sb wmask=4'b0100, wdata=0x00AB0000 @0x100 over 0xDEADBEEF; then lw -> 0xDEABBEEF.
// - Read addr 0x103 with rmask=4'b1000 -> rdata=full word at 0x100; resp held one cycle only, no re-accept in RESP cycle.
// - Change addr/wdata mid-WAIT -> response and write use captured values; assert rst mid-WAIT -> no resp, word unchanged.
// - rmask=F and wmask=F together with wdata=0x12345678 -> err=1 with resp, rdata=0, word becomes 0x12345678; LATENCY=1 build gives resp at T+2.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and the
// captured request record.
package dmem_responder_pkg;

   typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_resp_state_t;

   // Widest word index a 32-bit byte address can carry; builds use the low bits.
   localparam int DMEM_IDX_W = 30;

   typedef struct packed {
      logic [DMEM_IDX_W-1:0] idx;
      logic [3:0]            rmask;
      logic [3:0]            wmask;
      logic [31:0]           wdata;
   } dmem_req_t;

   function automatic logic req_present(input logic [3:0] rmask, input logic [3:0] wmask);
      return (|rmask) | (|wmask);
   endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Byte-writable word array: synchronous write with byte enables, registered
// read. No reset, so contents survive a core reset.
module dmem_byte_ram #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [3:0][7:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) mem[idx][b] <= wdata[b*8 +: 8];
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data-memory port: captures a request, waits
// LATENCY cycles, then commits the write or returns the read word with a
// one-cycle dmem_resp pulse.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int LATENCY    = 2,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        dmem_busy,
   output logic        dmem_err
);

   localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   if (LATENCY < 1) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be >= 1");
   end

   dmem_resp_state_t      state_q, state_d;
   logic [CW-1:0]         cnt_q;
   dmem_req_t             req_q;
   logic                  accept, commit;
   logic                  ram_we;
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic [31:0]           ram_rdata;
   logic                  unused_bits;

   assign unused_bits = ^{dmem_addr[31:DEPTH_LOG2+2], dmem_addr[1:0],
                          req_q.idx[DMEM_IDX_W-1:DEPTH_LOG2]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= DMEM_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         DMEM_IDLE: if (req_present(dmem_rmask, dmem_wmask)) begin
            accept  = 1'b1;
            state_d = DMEM_WAIT;
         end
         DMEM_WAIT: if (cnt_q == '0) begin
            commit  = 1'b1;
            state_d = DMEM_RESP;
         end
         DMEM_RESP: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         req_q      <= '0;
         dmem_rdata <= '0;
         dmem_resp  <= 1'b0;
         dmem_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q       <= CW'(LATENCY - 1);
            req_q.idx   <= DMEM_IDX_W'(dmem_addr[DEPTH_LOG2+1:2]);
            req_q.rmask <= dmem_rmask;
            req_q.wmask <= dmem_wmask;
            req_q.wdata <= dmem_wdata;
         end else if (state_q == DMEM_WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (commit) begin
            dmem_rdata <= (|req_q.wmask) ? 32'h0 : ram_rdata;
            dmem_resp  <= 1'b1;
            dmem_err   <= (|req_q.rmask) && (|req_q.wmask);
         end else if (state_q == DMEM_RESP) begin
            dmem_resp <= 1'b0;
            dmem_err  <= 1'b0;
         end
      end
   end

   // The RAM reads the live address on the accept edge so the word is ready
   // after one WAIT cycle, which LATENCY=1 depends on.
   assign ram_idx   = (state_q == DMEM_IDLE) ? dmem_addr[DEPTH_LOG2+1:2]
                                             : req_q.idx[DEPTH_LOG2-1:0];
   assign ram_we    = commit && (|req_q.wmask) && !rst;
   assign dmem_busy = (state_q != DMEM_IDLE);

   dmem_byte_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (req_q.wmask),
      .idx   (ram_idx),
      .wdata (req_q.wdata),
      .rdata (ram_rdata)
   );

endmodule
